wide_dma_tcdm_rr_arb: RTL and testbench

Round-robin arbiter that shares one wide DMA TCDM slave port among `NUM_REQ` wide DMA masters (DMA engines, cluster-to-cluster movers). It sits between the DMA request sources and the wide TCDM interconnect port. It forwards one request per cycle, locks the selection until granted, and records the owner of every granted transaction in an in-order ID FIFO. Responses are routed back to the issuing master.

---
 rtl/wide_dma_tcdm_rr_arb.sv | 144 ++++++++++++++
 tb/tb_wide_dma_tcdm_rr_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_dma_tcdm_rr_arb.sv
// Round-robin arbiter sharing one wide TCDM slave port among NUM_REQ DMA masters.
// Winners are locked until granted; an in-order ID FIFO routes responses back to their owner.
module wide_dma_tcdm_rr_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                s_req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_add_i,
    input  logic [NUM_REQ-1:0]                s_wen_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_be_i,
    output logic [NUM_REQ-1:0]                s_gnt_o,
    output logic [NUM_REQ-1:0]                s_r_valid_o,
    output logic [DATA_WIDTH-1:0]             s_r_rdata_o,
    output logic                              s_r_opc_o,
    output logic                              m_req_o,
    output logic [ADDR_WIDTH-1:0]             m_add_o,
    output logic                              m_wen_o,
    output logic [DATA_WIDTH-1:0]             m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           m_be_o,
    input  logic                              m_gnt_i,
    input  logic                              m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]             m_r_rdata_i,
    input  logic                              m_r_opc_i,
    output logic [$clog2(MAX_OUT+1)-1:0]      outstanding_o,
    output logic                              err_o
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] id_mem_q [MAX_OUT];

    logic [IDX_W-1:0] rr_sel, cand, sel;
    logic             rr_found;
    logic             full, empty, push, pop;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
            if (!rr_found && s_req_i[cand]) begin
                rr_sel   = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign sel   = lock_q ? lock_idx_q : rr_sel;
    assign full  = (count_q == CNT_W'(MAX_OUT));
    assign empty = (count_q == '0);

    assign m_req_o   = (|s_req_i) & ~full;
    assign m_add_o   = s_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_wen_o   = s_wen_i[sel];
    assign m_wdata_o = s_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign m_be_o    = s_be_i[sel*BE_WIDTH +: BE_WIDTH];

    assign push = m_req_o & m_gnt_i;
    assign pop  = m_r_valid_i & ~empty;

    assign s_r_rdata_o   = m_r_rdata_i;
    assign s_r_opc_o     = m_r_opc_i;
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    always_comb begin
        s_gnt_o = '0;
        if (push) s_gnt_o[sel] = 1'b1;
    end

    always_comb begin
        s_r_valid_o = '0;
        if (pop) s_r_valid_o[id_mem_q[rd_ptr_q]] = 1'b1;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;

        // A stalled request pins its winner; while full the existing lock just persists.
        if (push) begin
            rr_ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
            lock_d   = 1'b0;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else if (m_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end

        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (m_r_valid_i && empty) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_OUT); i++) id_mem_q[i] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            if (push) id_mem_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_wide_dma_tcdm_rr_arb.sv
// Bench for wide_dma_tcdm_rr_arb: directed phases plus random traffic against a
// queue-based reference model; a monitor pops expected cycle/grant/response records.
module tb_wide_dma_tcdm_rr_arb;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic [NR-1:0]      s_req_i = '0;
    logic [NR*AW-1:0]   s_add_i = '0;
    logic [NR-1:0]      s_wen_i = '0;
    logic [NR*DW-1:0]   s_wdata_i = '0;
    logic [NR*BW-1:0]   s_be_i = '0;
    logic [NR-1:0]      s_gnt_o, s_r_valid_o;
    logic [DW-1:0]      s_r_rdata_o;
    logic               s_r_opc_o;
    logic               m_req_o, m_wen_o;
    logic [AW-1:0]      m_add_o;
    logic [DW-1:0]      m_wdata_o;
    logic [BW-1:0]      m_be_o;
    logic               m_gnt_i = 1'b0, m_r_valid_i = 1'b0, m_r_opc_i = 1'b0;
    logic [DW-1:0]      m_r_rdata_i = '0;
    logic [CW-1:0]      outstanding_o;
    logic               err_o;

    wide_dma_tcdm_rr_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
        .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i), .m_r_opc_i(m_r_opc_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    // Clock: period 20; inputs change at negedge, model at +1, monitor at +3.
    always #10 clk = ~clk;

    typedef struct packed {
        logic          m_req;
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [CW-1:0] cnt;
        logic          err;
        logic [NR-1:0] gnt;
        logic [NR-1:0] rv;
    } cyc_t;
    typedef struct packed { logic [NR-1:0] vec; logic [AW-1:0] add; } gnt_t;
    typedef struct packed { logic [NR-1:0] vec; logic [DW-1:0] data; logic opc; } rsp_t;

    cyc_t exp_cyc_q[$];
    gnt_t exp_gnt_q[$];
    rsp_t exp_rsp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int            owner_q[$];
    int            ptr_m  = 0;
    int            lock_m = -1;
    bit            err_m  = 0;
    bit  [NR-1:0]  pend   = '0;
    logic [AW-1:0] addr_m [NR];
    logic          wen_m  [NR];
    logic [DW-1:0] wdata_m[NR];
    logic [BW-1:0] be_m   [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int outs();
        return owner_q.size();
    endfunction

    task automatic drive_cycle(input logic [NR-1:0] new_req, input logic gnt, input logic rv);
        int   sel;
        bit   mreq, hs, pop;
        cyc_t c;
        @(negedge clk);
        rst_ni = 1'b1;
        for (int k = 0; k < NR; k++) begin
            if (!pend[k] && new_req[k]) begin
                pend[k]    = 1'b1;
                addr_m[k]  = $urandom;
                wen_m[k]   = 1'($urandom_range(0, 1));
                wdata_m[k] = {$urandom, $urandom};
                be_m[k]    = 8'($urandom);
            end
            s_req_i[k]            = pend[k];
            s_add_i[k*AW +: AW]   = addr_m[k];
            s_wen_i[k]            = wen_m[k];
            s_wdata_i[k*DW +: DW] = wdata_m[k];
            s_be_i[k*BW +: BW]    = be_m[k];
        end
        m_gnt_i     = gnt;
        m_r_valid_i = rv;
        m_r_rdata_i = {$urandom, $urandom};
        m_r_opc_i   = 1'($urandom_range(0, 1));
        #1;
        mreq = (|pend) && (owner_q.size() < MO);
        sel  = -1;
        if (lock_m >= 0) sel = lock_m;
        else for (int i = 0; i < NR; i++) if (sel < 0 && pend[(ptr_m + i) % NR]) sel = (ptr_m + i) % NR;
        hs  = mreq && gnt;
        pop = rv && owner_q.size() > 0;
        c = '0;
        c.m_req = mreq;
        if (mreq) begin
            c.add = addr_m[sel]; c.wen = wen_m[sel]; c.wdata = wdata_m[sel]; c.be = be_m[sel];
        end
        c.cnt = CW'(owner_q.size());
        c.err = err_m;
        if (hs) c.gnt[sel] = 1'b1;
        if (pop) c.rv[owner_q[0]] = 1'b1;
        exp_cyc_q.push_back(c);
        if (pop) begin
            exp_rsp_q.push_back('{vec: c.rv, data: m_r_rdata_i, opc: m_r_opc_i});
            void'(owner_q.pop_front());
        end else if (rv) begin
            err_m = 1'b1;
        end
        if (hs) begin
            exp_gnt_q.push_back('{vec: c.gnt, add: addr_m[sel]});
            owner_q.push_back(sel);
            ptr_m   = (sel + 1) % NR;
            lock_m  = -1;
            pend[sel] = 1'b0;
        end else if (mreq) begin
            lock_m = sel;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (|pend || outs() > 0); n++) drive_cycle('0, 1'b1, outs() > 0);
    endtask

    // Monitor: compares every driven cycle and pops transaction records when the DUT presents them.
    initial begin
        cyc_t c;
        gnt_t g;
        rsp_t r;
        forever begin
            @(negedge clk);
            #3;
            if (exp_cyc_q.size() > 0) begin
                c = exp_cyc_q.pop_front();
                check("m_req", 64'(m_req_o), 64'(c.m_req));
                check("outstanding", 64'(outstanding_o), 64'(c.cnt));
                check("err", 64'(err_o), 64'(c.err));
                check("s_gnt", 64'(s_gnt_o), 64'(c.gnt));
                check("s_r_valid", 64'(s_r_valid_o), 64'(c.rv));
                if (c.m_req) begin
                    check("m_add", 64'(m_add_o), 64'(c.add));
                    check("m_wen", 64'(m_wen_o), 64'(c.wen));
                    check("m_wdata", m_wdata_o, c.wdata);
                    check("m_be", 64'(m_be_o), 64'(c.be));
                end
                if (|s_gnt_o) begin
                    if (exp_gnt_q.size() == 0) check("unexpected_gnt", 64'(s_gnt_o), 64'(0));
                    else begin
                        g = exp_gnt_q.pop_front();
                        check("gnt_owner", 64'(s_gnt_o), 64'(g.vec));
                        check("gnt_addr", 64'(m_add_o), 64'(g.add));
                    end
                end
                if (|s_r_valid_o) begin
                    if (exp_rsp_q.size() == 0) check("unexpected_rsp", 64'(s_r_valid_o), 64'(0));
                    else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_owner", 64'(s_r_valid_o), 64'(r.vec));
                        check("rsp_rdata", s_r_rdata_o, r.data);
                        check("rsp_opc", 64'(s_r_opc_o), 64'(r.opc));
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            addr_m[k] = '0; wen_m[k] = 1'b0; wdata_m[k] = '0; be_m[k] = '0;
        end
        repeat (3) @(negedge clk);

        // Reset state, then fairness with 1-cycle responses.
        drive_cycle('0, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++) drive_cycle(4'hF, 1'b1, outs() > 0);
        drain();

        // Lock: master 2 stalls, master 0 joins, 2 must still win first.
        repeat (3) drive_cycle(4'b0100, 1'b0, 1'b0);
        drive_cycle(4'b0001, 1'b0, 1'b0);
        drive_cycle('0, 1'b1, 1'b0);
        drive_cycle('0, 1'b1, 1'b1);
        drain();

        // Full: four handshakes without responses, then a pop with a request pending.
        repeat (6) drive_cycle(4'hF, 1'b1, 1'b0);
        drive_cycle('0, 1'b1, 1'b1);
        drive_cycle('0, 1'b1, 1'b0);
        drain();

        // Ordering 3,1,3 then a simultaneous push/pop and in-order responses.
        drive_cycle(4'b1000, 1'b1, 1'b0);
        drive_cycle(4'b0010, 1'b1, 1'b0);
        drive_cycle(4'b1000, 1'b1, 1'b0);
        drive_cycle(4'b0001, 1'b1, 1'b1);
        repeat (3) drive_cycle('0, 1'b0, 1'b1);

        // Random traffic.
        for (int n = 0; n < 400; n++)
            drive_cycle(NR'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                        outs() > 0 && $urandom_range(0, 2) != 0);
        drain();

        // Empty pop sets a sticky error.
        drive_cycle('0, 1'b0, 1'b1);
        repeat (3) drive_cycle(4'h3, 1'b1, 1'b0);

        // Asynchronous reset mid-burst clears count and error immediately.
        #4;
        rst_ni = 1'b0;
        #1;
        check("async_rst_outstanding", 64'(outstanding_o), 64'(0));
        check("async_rst_err", 64'(err_o), 64'(0));
        owner_q.delete();
        ptr_m = 0; lock_m = -1; err_m = 1'b0;
        drive_cycle('0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) drive_cycle(4'hF, 1'b1, outs() > 0);
        drain();
        repeat (2) @(negedge clk);

        check("cyc_q_empty", 64'(exp_cyc_q.size()), 64'(0));
        check("gnt_q_empty", 64'(exp_gnt_q.size()), 64'(0));
        check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
